// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encoding, default frame constants and the parity helper.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;
  localparam int MAX_DATA_BITS    = 9;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t RX_IDLE   = 3'd0;
  localparam rx_state_t RX_START  = 3'd1;
  localparam rx_state_t RX_DATA   = 3'd2;
  localparam rx_state_t RX_PARITY = 3'd3;
  localparam rx_state_t RX_STOP   = 3'd4;
  localparam rx_state_t RX_BREAK  = 3'd5;

  // Unused upper bits must be zero-filled by the caller.
  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous input, reset to RST_VAL.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= {2{RST_VAL}};
    else     ff <= {ff[0], d};
  end

  assign q = ff[1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with mid-bit sampling, false-start rejection and framing errors.
// Define UART_RX_PARITY_EN to expect one parity bit after the data bits.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 received_byte,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = RX_PARITY;
`else
  localparam rx_state_t AFTER_DATA = RX_STOP;
`endif

  logic                 s;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic parity_err_q;
`endif

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bit_in),
    .q   (s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RX_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      stop_idx      <= 1'b0;
      shift         <= '0;
      data_out      <= '0;
      received_byte <= 1'b0;
      frame_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit       <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      received_byte <= 1'b0;
      frame_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
      case (state)
        RX_IDLE: begin
          if (!s) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        // Re-check the start bit at its midpoint to reject glitches.
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            shift <= {s, shift[DATA_BITS-1:1]};
            if (bit_idx == LAST_IDX) begin
              stop_idx <= 1'b0;
              state    <= AFTER_DATA;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (cnt == LAST_CNT) begin
            cnt     <= '0;
            par_bit <= s;
            state   <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (!s) begin
              frame_err <= 1'b1;
              state     <= RX_BREAK;
            end else if (stop_idx == LAST_STOP) begin
              data_out      <= shift;
              received_byte <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_q  <= par_bit != parity_of(MAX_DATA_BITS'(shift), 1'(PARITY_ODD));
`endif
              state         <= RX_IDLE;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A stuck-low line must return high before a new start is accepted.
        RX_BREAK: begin
          if (s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param at 4 clocks per bit, 8 data bits, 1 stop bit.
module tb_uart_rx_param;

  localparam int CPB = 4;

  typedef struct {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic [7:0] data_out;
  logic       received_byte;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  exp_t       exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] last_good   = 8'h00;

  uart_rx_param #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8),
    .STOP_BITS    (1),
    .PARITY_ODD   (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bit_in        (bit_in),
    .data_out      (data_out),
    .received_byte (received_byte),
    .frame_err     (frame_err),
    .parity_err    (parity_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && (received_byte || frame_err || parity_err)) begin
      if (received_byte && frame_err)
        chk("pulse_overlap", 32'(1), 32'(0));
      else if (exp_q.size() == 0)
        chk("unexpected_pulse", {29'd0, received_byte, frame_err, parity_err}, 32'(0));
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_err", 32'(frame_err), 32'(e.ferr));
        chk("received_byte", 32'(received_byte), 32'(!e.ferr));
        chk("parity_err", 32'(parity_err), 32'(e.perr));
        chk("data_out", 32'(data_out), 32'(e.data));
      end
    end
  end

  task automatic send_bit(input logic b);
    bit_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    exp_t e;
    if (stop_v) begin
      e.ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
      e.perr = par_flip;
`else
      e.perr = 1'b0;
`endif
      e.data    = d;
      last_good = d;
    end else begin
      e.ferr = 1'b1;
      e.perr = 1'b0;
      e.data = last_good;
    end
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_v);
  endtask

  task automatic idle(input int n);
    bit_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_busy;
    rst    = 1'b1;
    bit_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pulses", {29'd0, received_byte, frame_err, parity_err}, 32'h0);
    idle(4);

    // Single frame
    send_frame(8'h35, 1'b1, 1'b0);
    idle(10);
    chk("busy_after_35", 32'(busy), 32'h0);

    // Back-to-back, no idle gap
    send_frame(8'h35, 1'b1, 1'b0);
    send_frame(8'hCE, 1'b1, 1'b0);
    idle(10);
    chk("busy_after_b2b", 32'(busy), 32'h0);
    chk("data_after_b2b", 32'(data_out), 32'hCE);

    // One-clock glitch: start entered then rejected
    bit_in = 1'b0;
    @(negedge clk);
    bit_in   = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    chk("glitch_busy_seen", 32'(saw_busy), 32'h1);
    chk("glitch_busy_end", 32'(busy), 32'h0);
    idle(4);

    // Framing error, then line held low
    send_frame(8'hA5, 1'b0, 1'b0);
    bit_in = 1'b0;
    repeat (20) @(negedge clk);
    chk("break_busy", 32'(busy), 32'h1);
    chk("break_data_kept", 32'(data_out), 32'hCE);
    idle(8);
    chk("break_release", 32'(busy), 32'h0);

    // Reset mid-way through data bit 4
    bit_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h35 >> i));
    bit_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    last_good = 8'h00;
    idle(4);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_data", 32'(data_out), 32'h0);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(10);
    chk("data_after_abort", 32'(data_out), 32'h5A);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h35, 1'b1, 1'b0);
    idle(6);
    send_frame(8'h35, 1'b1, 1'b1);
    idle(10);
`endif

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised next-generation UART receiver. Configurable clocks-per-bit with mid-bit sampling, configurable data width and stop-bit count, false-start rejection, and framing-error reporting. Sits between the external serial RX pin and the byte-level consumer. Replaces the fixed one-clock-per-bit, 8-bit receiver.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4
DATA_BITS, 8, data bits per frame (5..9), LSB first
STOP_BITS, 1, stop bits per frame (1 or 2)
PARITY_ODD, 0, parity sense when parity is compiled in (0 = even, 1 = odd)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
bit_in  input  1  asynchronous serial line; idle high
data_out  output  DATA_BITS  last good received word; held until the next good frame
received_byte  output  1  one-cycle pulse when data_out updates
frame_err  output  1  one-cycle pulse when a stop bit is sampled low
parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 without the macro
busy  output  1  high while state != IDLE

Behaviour:
- Reset (sync, active-high, clk rising edge): data_out=0, received_byte=0, frame_err=0, parity_err=0, busy=0, state=IDLE, counters=0, synchroniser flops=1.
- bit_in passes through a 2-flop synchroniser; s = its output. All decisions use s. Input-to-s latency is 2 clk.
- Constants: HALF = CLKS_PER_BIT/2. cnt is $clog2(CLKS_PER_BIT) bits wide. bit_idx is $clog2(DATA_BITS) bits wide.
- IDLE: if s==0, go to START with cnt=0.
- START: cnt increments each clk. At cnt==HALF-1:
  - s==0: go to DATA, cnt=0, bit_idx=0.
  - s==1: false start; return to IDLE with no output pulse.
- DATA: at cnt==CLKS_PER_BIT-1, shift s into the shift register MSB (LSB-first assembly) and set cnt=0.
  - After bit_idx==DATA_BITS-1, go to PARITY (macro defined) or STOP.
  - Otherwise increment bit_idx.
- PARITY (macro only): sample at cnt==CLKS_PER_BIT-1, then go to STOP.
- STOP: sample at cnt==CLKS_PER_BIT-1; repeat for STOP_BITS stop bits.
  - All stop bits high: on the sample cycle register data_out<=shift; received_byte=1 on the next clk for exactly one cycle; go to IDLE.
  - Any stop bit low: frame_err=1 for one cycle; data_out unchanged; no received_byte; go to BREAK.
- BREAK: wait until s==1, then go to IDLE. A line held low never produces repeated frames.
- Back-to-back frames: a start edge on the first IDLE clk after STOP is accepted.
- Pulse rules: received_byte and frame_err are never high in the same cycle.
- rst mid-frame: the partial frame is discarded with no pulses, and the receiver resumes in IDLE.

Optional Feature:
UART_RX_PARITY_EN
- Defined: one parity bit follows the data bits.
  - Expected parity = ^data ^ PARITY_ODD.
  - On mismatch: parity_err pulses for one cycle together with received_byte, and data_out is still updated.
  - Framing error takes precedence: on frame_err, parity_err stays 0.
- Undefined: no PARITY state, parity_err=0 constantly, PARITY_ODD ignored.

Decomposition:
- Package uart_pkg:
  - rx state enum (IDLE, START, DATA, PARITY, STOP, BREAK)
  - parity-compute function
  - default CLKS_PER_BIT/DATA_BITS constants shared with the future transmitter
- Sub-module uart_sync: 2-flop synchroniser with parametrised reset value (1 for the RX line).

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless stated):
- Frame 0x35 (start 0, bits 1,0,1,0,1,1,0,0, stop 1) -> single received_byte pulse, data_out=0x35, frame_err=0, busy low afterwards.
- Back-to-back 0x35 then 0xCE with no idle gap -> two pulses; data_out=0x35 then 0xCE.
- 1-clk low glitch on idle line -> START entered, rejected at HALF sample; no pulses, busy returns to 0 within 4 clk.
- 0xA5 with stop bit 0, line then held low 20 clk -> one frame_err pulse, data_out keeps its prior value, busy stays high until the line goes high, no further pulses.
- rst asserted for 1 clk during data bit 4 of 0x35, then a clean 0x5A -> no pulse for the aborted frame; data_out=0x5A with one pulse.
- UART_RX_PARITY_EN, PARITY_ODD=0:
  - 0x35 with parity bit 0 -> received_byte pulse only, parity_err=0.
  - Same frame with parity bit 1 -> received_byte and parity_err pulse together.
